// File: rtl/he_lb_seq_pkg.sv
// he_lb_seq_pkg: shared CSR map, INFO0 layout, FSM states and error codes for the HE-LB sequencer.
package he_lb_seq_pkg;
  localparam logic [11:0] OFF_DSML    = 12'h110;
  localparam logic [11:0] OFF_DSMH    = 12'h114;
  localparam logic [11:0] OFF_SRC     = 12'h120;
  localparam logic [11:0] OFF_DST     = 12'h128;
  localparam logic [11:0] OFF_NUM     = 12'h130;
  localparam logic [11:0] OFF_CTL     = 12'h138;
  localparam logic [11:0] OFF_CFG     = 12'h140;
  localparam logic [11:0] OFF_STATUS0 = 12'h160;
  localparam logic [11:0] OFF_ERROR   = 12'h170;
  localparam logic [11:0] OFF_INFO0   = 12'h180;
  localparam logic [63:0] CTL_RESET = 64'd0;
  localparam logic [63:0] CTL_RUN   = 64'd1;
  localparam logic [63:0] CTL_START = 64'd3;
  localparam logic [63:0] CTL_STOP  = 64'd7;
  typedef struct packed {
    logic [45:0] rsvd;
    logic [1:0]  bus_width_shift;
    logic [15:0] misc;
  } t_info0;
  // Encoding is sequential so linear write steps advance by +1.
  typedef logic [4:0] t_state;
  localparam t_state S_IDLE     = 5'd0;
  localparam t_state S_RD_INFO0 = 5'd1;
  localparam t_state S_CHECK    = 5'd2;
  localparam t_state S_WR_DSML  = 5'd3;
  localparam t_state S_WR_DSMH  = 5'd4;
  localparam t_state S_WR_SRC   = 5'd5;
  localparam t_state S_WR_DST   = 5'd6;
  localparam t_state S_WR_NUM   = 5'd7;
  localparam t_state S_WR_CFG   = 5'd8;
  localparam t_state S_WR_CTL0  = 5'd9;
  localparam t_state S_WR_CTL1  = 5'd10;
  localparam t_state S_WR_CTL3  = 5'd11;
  localparam t_state S_GAP      = 5'd12;
  localparam t_state S_RD_STAT  = 5'd13;
  localparam t_state S_RD_ERR   = 5'd14;
  localparam t_state S_WR_STOP  = 5'd15;
  localparam t_state S_FINISH   = 5'd16;
  typedef enum logic [2:0] {
    ERR_OK      = 3'd0,
    ERR_NUM0    = 3'd1,
    ERR_ALIGN   = 3'd2,
    ERR_TIMEOUT = 3'd3,
    ERR_HELB    = 3'd4
  } t_err;
  function automatic logic [63:0] bus_bytes(input logic [1:0] shift);
    return 64'd32 << shift;
  endfunction
endpackage

// File: rtl/he_lb_mmio_req.sv
// he_lb_mmio_req: MMIO request register slice with read-pending tracking; one issue pulse in, one completion pulse out.
module he_lb_mmio_req #(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic              issue_write,
  input  logic              issue_dw,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [63:0]       issue_wdata,
  input  logic              req_ready,
  input  logic              rsp_valid,
  output logic              req_valid,
  output logic              req_write,
  output logic              req_dw,
  output logic [ADDR_W-1:0] req_addr,
  output logic [63:0]       req_wdata,
  output logic              idle,
  output logic              cpl
);
  logic rd_pend;
  assign idle = !req_valid && !rd_pend;
  assign cpl = (req_valid && req_ready && req_write) || (rd_pend && rsp_valid);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid <= 1'b0;
      req_write <= 1'b0;
      req_dw    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      rd_pend   <= 1'b0;
    end else begin
      if (issue) begin
        req_valid <= 1'b1;
        req_write <= issue_write;
        req_dw    <= issue_dw;
        req_addr  <= issue_addr;
        req_wdata <= issue_wdata;
      end else if (req_valid && req_ready) begin
        req_valid <= 1'b0;
      end
      if (req_valid && req_ready && !req_write) rd_pend <= 1'b1;
      else if (rd_pend && rsp_valid) rd_pend <= 1'b0;
    end
  end
endmodule

// File: rtl/he_lb_cfg_sequencer.sv
// he_lb_cfg_sequencer: MMIO master that programs, runs, polls and stops one HE-LB loopback pass.
module he_lb_cfg_sequencer
  import he_lb_seq_pkg::*;
#(
  parameter int          ADDR_W     = 20,
  parameter int unsigned CSR_BASE   = 0,
  parameter int          POLL_GAP   = 64,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [63:0]       src_addr,
  input  logic [63:0]       dst_addr,
  input  logic [63:0]       dsm_base,
  input  logic [31:0]       num_lines,
  input  logic [63:0]       cfg_word,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic              req_dw,
  output logic [ADDR_W-1:0] req_addr,
  output logic [63:0]       req_wdata,
  input  logic              rsp_valid,
  input  logic [63:0]       rsp_data,
  output logic              busy,
  output logic              done,
  output logic [2:0]        err_code,
  output logic [63:0]       info0_q
);
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam int PW = $clog2(POLL_LIMIT + 1) > 11 ? $clog2(POLL_LIMIT + 1) : 11;
  t_state          state;
  t_info0          info0_r;
  logic [63:0]     src_q, dst_q, dsm_q, cfg_q, rq_wdata;
  logic [31:0]     num_q;
  logic [GW-1:0]   gap_cnt;
  logic [PW-1:0]   poll_cnt, poll_nxt;
  logic [11:0]     rq_off;
  logic            is_req, issue, idle, cpl, rq_write, rq_dw, misaligned;
  assign info0_q = info0_r;
  assign is_req = state inside {S_RD_INFO0, S_WR_DSML, S_WR_DSMH, S_WR_SRC, S_WR_DST, S_WR_NUM,
                                S_WR_CFG, S_WR_CTL0, S_WR_CTL1, S_WR_CTL3, S_RD_STAT, S_RD_ERR, S_WR_STOP};
  assign issue = is_req && idle;
  assign misaligned = |((src_q | dst_q) & (bus_bytes(info0_r.bus_width_shift) - 64'd1));
  assign poll_nxt = &poll_cnt ? poll_cnt : poll_cnt + 1'b1;
  always_comb begin
    rq_write = 1'b1;
    rq_dw    = 1'b0;
    rq_off   = OFF_CTL;
    rq_wdata = '0;
    case (state)
      S_RD_INFO0: begin rq_write = 1'b0; rq_off = OFF_INFO0; end
      S_WR_DSML:  begin rq_dw = 1'b1; rq_off = OFF_DSML; rq_wdata = {32'd0, dsm_q[31:0]}; end
      S_WR_DSMH:  begin rq_dw = 1'b1; rq_off = OFF_DSMH; rq_wdata = {32'd0, dsm_q[63:32]}; end
      S_WR_SRC:   begin rq_off = OFF_SRC; rq_wdata = src_q >> 6; end
      S_WR_DST:   begin rq_off = OFF_DST; rq_wdata = dst_q >> 6; end
      S_WR_NUM:   begin rq_off = OFF_NUM; rq_wdata = {32'd0, num_q - 32'd1}; end
      S_WR_CFG:   begin rq_off = OFF_CFG; rq_wdata = cfg_q; end
      S_WR_CTL0:  rq_wdata = CTL_RESET;
      S_WR_CTL1:  rq_wdata = CTL_RUN;
      S_WR_CTL3:  rq_wdata = CTL_START;
      S_RD_STAT:  begin rq_write = 1'b0; rq_off = OFF_STATUS0; end
      S_RD_ERR:   begin rq_write = 1'b0; rq_off = OFF_ERROR; end
      S_WR_STOP:  rq_wdata = CTL_STOP;
      default:    ;
    endcase
  end
  he_lb_mmio_req #(.ADDR_W(ADDR_W)) u_req (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue       (issue),
    .issue_write (rq_write),
    .issue_dw    (rq_dw),
    .issue_addr  (ADDR_W'(CSR_BASE) + ADDR_W'(rq_off)),
    .issue_wdata (rq_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_dw      (req_dw),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .idle        (idle),
    .cpl         (cpl)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_code <= ERR_OK;
      info0_r  <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      dsm_q    <= '0;
      cfg_q    <= '0;
      num_q    <= '0;
      gap_cnt  <= '0;
      poll_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          src_q    <= src_addr;
          dst_q    <= dst_addr;
          dsm_q    <= dsm_base;
          cfg_q    <= cfg_word;
          num_q    <= num_lines;
          busy     <= 1'b1;
          gap_cnt  <= '0;
          poll_cnt <= '0;
          err_code <= num_lines == 32'd0 ? ERR_NUM0 : ERR_OK;
          state    <= num_lines == 32'd0 ? S_FINISH : S_RD_INFO0;
        end
        S_RD_INFO0: if (cpl) begin
          info0_r <= rsp_data;
          state   <= S_CHECK;
        end
        S_CHECK: begin
          if (misaligned) err_code <= ERR_ALIGN;
          state <= misaligned ? S_FINISH : S_WR_DSML;
        end
        S_WR_DSML, S_WR_DSMH, S_WR_SRC, S_WR_DST, S_WR_NUM, S_WR_CFG,
        S_WR_CTL0, S_WR_CTL1, S_WR_CTL3, S_WR_STOP: if (cpl) state <= state + 5'd1;
        S_GAP: begin
          gap_cnt <= gap_cnt == GW'(POLL_GAP - 1) ? '0 : gap_cnt + 1'b1;
          if (gap_cnt == GW'(POLL_GAP - 1)) state <= S_RD_STAT;
        end
        S_RD_STAT: if (cpl) begin
          if (rsp_data[31:0] >= num_q) begin
            state <= S_RD_ERR;
          end else begin
            poll_cnt <= poll_nxt;
            if (poll_nxt == PW'(POLL_LIMIT)) err_code <= ERR_TIMEOUT;
            state <= poll_nxt == PW'(POLL_LIMIT) ? S_WR_STOP : S_GAP;
          end
        end
        S_RD_ERR: if (cpl) begin
          if (|rsp_data) err_code <= ERR_HELB;
          state <= S_WR_STOP;
        end
        S_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_he_lb_cfg_sequencer.sv
// tb_he_lb_cfg_sequencer: table-driven directed bench with an MMIO responder model and corner-case sequences.
module tb_he_lb_cfg_sequencer;
  logic        clk, rst_n, start, req_ready, rsp_valid;
  logic [63:0] src_addr, dst_addr, dsm_base, cfg_word, rsp_data;
  logic [31:0] num_lines;
  logic        req_valid, req_write, req_dw, busy, done;
  logic [19:0] req_addr;
  logic [63:0] req_wdata, info0_q;
  logic [2:0]  err_code;
  he_lb_cfg_sequencer #(.ADDR_W(20), .CSR_BASE(0), .POLL_GAP(3), .POLL_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .dsm_base(dsm_base), .num_lines(num_lines), .cfg_word(cfg_word), .req_valid(req_valid),
    .req_ready(req_ready), .req_write(req_write), .req_dw(req_dw), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .done(done), .err_code(err_code), .info0_q(info0_q)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [63:0] src, dst, dsm, cfg;
    logic [31:0] num;
    logic [1:0]  shift;
    logic [31:0] stat_first, stat_after;
    logic [63:0] err_reg;
    logic [2:0]  exp_err;
    int          exp_stat;
  } vec_t;
  typedef struct {
    logic [19:0] addr;
    logic [63:0] data;
    logic        dw;
  } wr_t;
  vec_t        vecs[8];
  wr_t         wlog[$];
  int          n_checks = 0, n_fail = 0;
  int          info_reads = 0, stat_reads = 0, err_reads = 0, rsp_cnt = 0, stall_left = 0;
  bit          saw_valid = 0, hold_on = 0;
  logic [19:0] stall_addr = 20'hFFFFF, hold_addr = '0;
  logic [63:0] hold_data = '0, rsp_hold = '0, cur_info = '0, cur_err = '0;
  logic [31:0] cur_first = '0, cur_after = '0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // MMIO responder: drives ready/response on the falling edge, logs accepted requests.
  always @(negedge clk) begin
    if (!rst_n) begin
      rsp_valid = 1'b0;
      rsp_cnt   = 0;
      hold_on   = 1'b0;
      req_ready = 1'b1;
    end else begin
      rsp_valid = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_data  = rsp_hold;
        end
      end
      req_ready = !(req_valid && req_addr == stall_addr && stall_left > 0);
      if (req_valid) saw_valid = 1'b1;
      if (hold_on && req_valid) begin
        check("stall_addr_stable", 64'(req_addr), 64'(hold_addr));
        check("stall_wdata_stable", req_wdata, hold_data);
      end
      if (!req_ready) begin
        if (!hold_on) begin
          hold_on   = 1'b1;
          hold_addr = req_addr;
          hold_data = req_wdata;
        end
        stall_left--;
      end
      if (req_valid && req_ready) begin
        hold_on = 1'b0;
        if (req_write) begin
          wlog.push_back('{req_addr, req_wdata, req_dw});
        end else begin
          rsp_cnt = 2;
          case (req_addr)
            20'h180: begin rsp_hold = cur_info; info_reads++; end
            20'h160: begin rsp_hold = {32'd0, stat_reads == 0 ? cur_first : cur_after}; stat_reads++; end
            20'h170: begin rsp_hold = cur_err; err_reads++; end
            default: rsp_hold = '0;
          endcase
        end
      end
    end
  end
  task automatic apply(input vec_t v);
    @(negedge clk);
    src_addr   = v.src;
    dst_addr   = v.dst;
    dsm_base   = v.dsm;
    cfg_word   = v.cfg;
    num_lines  = v.num;
    cur_info   = 64'hABCD_0000_00C0_0345 | (64'(v.shift) << 16);
    cur_first  = v.stat_first;
    cur_after  = v.stat_after;
    cur_err    = v.err_reg;
    wlog.delete();
    info_reads = 0;
    stat_reads = 0;
    err_reads  = 0;
    saw_valid  = 1'b0;
    start      = 1'b1;
  endtask
  task automatic run_pass(input int i, input bit poke);
    vec_t        v;
    bit          got, full;
    int          lat;
    logic [19:0] ea [10];
    logic [63:0] ed [10];
    v = vecs[i];
    apply(v);
    @(negedge clk);
    start = 1'b0;
    check("busy_at_start", 64'(busy), 64'd1);
    got = 1'b0;
    lat = 0;
    while (!got && lat < 600) begin
      if (poke && lat == 6) begin
        start     = 1'b1;
        src_addr  = 64'h1020;
        num_lines = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
      got = done;
    end
    start = 1'b0;
    full = v.exp_err == 3'd0 || v.exp_err == 3'd3 || v.exp_err == 3'd4;
    check("done_seen", 64'(got), 64'd1);
    check("err_code", 64'(err_code), 64'(v.exp_err));
    check("busy_at_done", 64'(busy), 64'd0);
    check("info0_reads", 64'(info_reads), v.num == 0 ? 64'd0 : 64'd1);
    check("status0_reads", 64'(stat_reads), 64'(v.exp_stat));
    check("error_reads", 64'(err_reads), (v.exp_err == 3'd0 || v.exp_err == 3'd4) ? 64'd1 : 64'd0);
    check("write_count", 64'(wlog.size()), full ? 64'd10 : 64'd0);
    if (v.num != 0) check("info0_q", info0_q, cur_info);
    if (v.num == 0) begin
      check("num0_latency_le3", 64'(lat + 1 <= 3), 64'd1);
      check("num0_no_valid", 64'(saw_valid), 64'd0);
    end
    ea = '{20'h110, 20'h114, 20'h120, 20'h128, 20'h130, 20'h140, 20'h138, 20'h138, 20'h138, 20'h138};
    ed = '{{32'd0, v.dsm[31:0]}, {32'd0, v.dsm[63:32]}, v.src >> 6, v.dst >> 6, {32'd0, v.num - 32'd1},
           v.cfg, 64'd0, 64'd1, 64'd3, 64'd7};
    if (full && wlog.size() == 10) begin
      for (int k = 0; k < 10; k++) begin
        check($sformatf("wr%0d_addr", k), 64'(wlog[k].addr), 64'(ea[k]));
        check($sformatf("wr%0d_data", k), wlog[k].data, ed[k]);
        check($sformatf("wr%0d_dw", k), 64'(wlog[k].dw), k < 2 ? 64'd1 : 64'd0);
      end
    end
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("err_held", 64'(err_code), 64'(v.exp_err));
  endtask
  initial begin
    int w;
    rst_n = 1'b0; start = 1'b0; req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
    src_addr = '0; dst_addr = '0; dsm_base = '0; cfg_word = '0; num_lines = '0;
    //          src            dst            dsm                     cfg                     num     sh    first   after   err_reg                  exp  stat
    vecs[0] = '{64'h1000,      64'h2000,      64'h0000_0001_2345_6780, 64'hDEAD_BEEF_0000_0011, 32'd8,  2'd1, 32'd3,  32'd8,  64'd0,                   3'd0, 2};
    vecs[1] = '{64'h1020,      64'h2000,      64'h0,                   64'h0,                   32'd8,  2'd1, 32'd8,  32'd8,  64'd0,                   3'd2, 0};
    vecs[2] = '{64'h1020,      64'h2000,      64'h0,                   64'h0,                   32'd0,  2'd1, 32'd8,  32'd8,  64'd0,                   3'd1, 0};
    vecs[3] = '{64'h1020,      64'h3000,      64'h0000_00AB_CDEF_0040, 64'h5,                   32'd5,  2'd0, 32'd0,  32'd0,  64'd0,                   3'd3, 4};
    vecs[4] = '{64'h4080,      64'h8000,      64'h8000_0000_0000_0000, 64'h1,                   32'd2,  2'd2, 32'd2,  32'd2,  64'd5,                   3'd4, 1};
    vecs[5] = '{64'h10000,     64'h20080,     64'h0,                   64'h0,                   32'd4,  2'd3, 32'd4,  32'd4,  64'd0,                   3'd2, 0};
    vecs[6] = '{64'h300,       64'h1000,      64'h0000_0000_FFFF_FFC0, 64'h7,                   32'd1,  2'd3, 32'd1,  32'd1,  64'd0,                   3'd0, 1};
    vecs[7] = '{64'h40,        64'h80,        64'h0000_1111_0000_2222, 64'h3,                   32'h10, 2'd1, 32'd0,  32'h20, 64'h0000_0001_0000_0000, 3'd4, 2};
    repeat (3) @(negedge clk);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_info0_q", info0_q, 64'd0);
    check("rst_req_addr", 64'(req_addr), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) run_pass(i, 1'b0);
    stall_addr = 20'h128;
    stall_left = 5;
    run_pass(0, 1'b0);
    check("stall_consumed", 64'(stall_left), 64'd0);
    stall_addr = 20'hFFFFF;
    run_pass(0, 1'b1);
    apply(vecs[3]);
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (wlog.size() < 9 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("reached_gap", 64'(wlog.size()), 64'd9);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_req_valid", 64'(req_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_err_code", 64'(err_code), 64'd0);
    check("midrst_info0_q", info0_q, 64'd0);
    @(negedge clk);
    check("midrst_req_valid_next", 64'(req_valid), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    run_pass(0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/he_lb_cfg_sequencer.md
Name: he_lb_cfg_sequencer

Overview:
- Hardware MMIO master that programs and runs one HE-LB loopback pass. Sits directly upstream of the HE-LB CSR block.
- Sequence: read INFO0, validate buffer alignment against the reported host bus width, write DSM, SRC, DST, NUM_LINES and CFG, step CTL through reset, run and start, poll STATUS0 until the expected line count is reached, then stop.
- Replaces the bench-side register sequence in system-level regressions.

Parameters:
- ADDR_W, 20, MMIO byte-address width.
- CSR_BASE, 0, byte offset of the HE-LB feature added to every CSR offset.
- POLL_GAP, 64, idle cycles between successive STATUS0 reads (≥1).
- POLL_LIMIT, 1024, STATUS0 reads before declaring timeout (≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a pass when idle.
- src_addr  in  64  source buffer byte address.
- dst_addr  in  64  destination buffer byte address.
- dsm_base  in  64  DSM byte address.
- num_lines  in  32  line count to transfer.
- cfg_word  in  64  value written to CFG.
- req_valid  out  1  MMIO request valid.
- req_ready  in  1  MMIO request accepted.
- req_write  out  1  1 = write, 0 = read.
- req_dw  out  1  1 = 32-bit access, 0 = 64-bit access.
- req_addr  out  ADDR_W  byte address.
- req_wdata  out  64  write data; 32-bit accesses use bits [31:0].
- rsp_valid  in  1  read response valid.
- rsp_data  in  64  read data.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at end of pass.
- err_code  out  3  0 = ok, 1 = num_lines zero, 2 = misaligned, 3 = timeout, 4 = HE-LB ERROR nonzero; valid at done, held until next start.
- info0_q  out  64  captured INFO0.

Behaviour:
- Reset: all outputs 0; state IDLE; poll and gap counters 0.
- Input capture: on start in IDLE, latch all inputs and set busy the next cycle. start while busy is ignored.
- num_lines == 0: go directly to FINISH with err 1. No MMIO is issued.
- Handshake:
  - req_valid stays high, with all request fields stable, until req_ready.
  - Writes complete on acceptance.
  - Reads wait for rsp_valid after acceptance; rsp_valid outside a pending read is ignored.
  - A response in the same cycle as acceptance is not legal and is not handled.
- States, in order; each write advances on acceptance:
  - RD_INFO0: 64-bit read of 0x180; store info0_q.
  - CHECK (1 cycle): bus_bytes = 32 << info0[17:16]. If (src_addr | dst_addr) & (bus_bytes-1) ≠ 0, go to FINISH with err 2.
  - WR_DSML: 32-bit write of 0x110 with dsm[31:0].
  - WR_DSMH: 32-bit write of 0x114 with dsm[63:32].
  - WR_SRC: 64-bit write of 0x120 with src >> 6.
  - WR_DST: 64-bit write of 0x128 with dst >> 6.
  - WR_NUM: 64-bit write of 0x130 with zero-extended num_lines − 1.
  - WR_CFG: 64-bit write of 0x140 with cfg_word.
  - WR_CTL0: write 0x138 = 0.
  - WR_CTL1: write 0x138 = 1.
  - WR_CTL3: write 0x138 = 3.
  - GAP: wait POLL_GAP cycles.
  - RD_STAT: 64-bit read of 0x160. If rsp[31:0] ≥ num_lines, go to RD_ERR. Otherwise increment the poll count; if poll count == POLL_LIMIT, go to WR_STOP with err 3; else return to GAP.
  - RD_ERR: read 0x170; nonzero sets err 4.
  - WR_STOP: write 0x138 = 7. Always issued once CTL has been written, including on timeout.
  - FINISH: pulse done, drop busy, return to IDLE.
- Addressing: all addresses are CSR_BASE + offset, truncated to ADDR_W.
- Poll counter: saturating, 11 bits minimum, cleared at each start.
- Reset mid-operation: immediate return to IDLE with req_valid low. An outstanding read response after reset is ignored.

Decomposition:
- Shared package he_lb_seq_pkg holds:
  - CSR offset constants, matching the HE-LB CSR map already in use.
  - t_info0 struct and the bus_bytes helper.
  - State enum.
  - Error-code enum.
  - CTL value constants 0/1/3/7.
- One natural sub-module: he_lb_mmio_req. It holds the valid/ready register slice plus the read-pending flag and presents a single "issue / complete" pulse interface to the FSM.

Test Plan:
- Nominal pass: info0 bus_width_shift = 1 (64 B); src 0x1000, dst 0x2000, num_lines 8; STATUS0 returns 3 then 8. Expected writes, in order: 0x120 ← 0x40, 0x128 ← 0x80, 0x130 ← 7, CTL 0, 1, 3, 7. Exactly two STATUS0 reads; done with err 0.
- Misaligned: src 0x1020 with 64 B bus → RD_INFO0 only, then done with err 2 and no writes.
- num_lines 0 → done within 3 cycles, err 1, req_valid never asserted.
- Timeout: POLL_LIMIT 4, STATUS0 always 0 → 4 reads, CTL ← 7 write, err 3.
- Backpressure: req_ready low for 5 cycles on WR_DST → req_addr and req_wdata stable, no skipped or duplicate write.
- Reset during GAP → outputs zero next cycle; a fresh start reruns from RD_INFO0. A start pulse while busy has no effect.
